// File: rtl/controlador_minado_pkg.sv
// controlador_minado_pkg: shared state encoding and field widths for the nonce-search sequencer
package controlador_minado_pkg;
    localparam int NONCE_W  = 32;
    localparam int DATA_W   = 96;
    localparam int BLOQUE_W = 128;
    localparam int HASH_W   = 24;
    localparam int TARGET_W = 8;
    localparam int CUENTA_W = 4;
    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        ESPERAR = 3'd1,
        EVALUAR = 3'd2,
        EXITO   = 3'd3,
        AGOTADO = 3'd4
    } estado_t;
endpackage

// File: rtl/controlador_minado_if.sv
// controlador_minado_if: request/datapath/result bundle; ciclos present only with CONTADOR_CICLOS_EN
interface controlador_minado_if;
    import controlador_minado_pkg::*;
    logic                inicio;
    logic [DATA_W-1:0]   bloque_datos;
    logic [TARGET_W-1:0] target;
    logic                hash_terminado;
    logic [HASH_W-1:0]   hash_bounty;
    logic [BLOQUE_W-1:0] bloque;
    logic [TARGET_W-1:0] target_out;
    logic                ocupado;
    logic                terminado;
    logic                agotado;
    logic [NONCE_W-1:0]  nonce_encontrado;
    logic [HASH_W-1:0]   hash_encontrado;
`ifdef CONTADOR_CICLOS_EN
    logic [31:0]         ciclos;
`endif
    modport master (
        output inicio, bloque_datos, target, hash_terminado, hash_bounty,
`ifdef CONTADOR_CICLOS_EN
        input ciclos,
`endif
        input bloque, target_out, ocupado, terminado, agotado, nonce_encontrado, hash_encontrado
    );
    modport slave (
        input inicio, bloque_datos, target, hash_terminado, hash_bounty,
`ifdef CONTADOR_CICLOS_EN
        output ciclos,
`endif
        output bloque, target_out, ocupado, terminado, agotado, nonce_encontrado, hash_encontrado
    );
endinterface

// File: rtl/controlador_minado_contador_espera.sv
// contador_espera: loadable down-counter whose zero flag ends the per-nonce datapath wait
module contador_espera
    import controlador_minado_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_cargar,
    input  logic [CUENTA_W-1:0] i_valor,
    input  logic                i_decrementar,
    output logic                o_cero
);
    logic [CUENTA_W-1:0] r_cuenta;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_cuenta <= '0;
        else if (i_cargar) r_cuenta <= i_valor;
        else if (i_decrementar && r_cuenta != '0) r_cuenta <= r_cuenta - 1'b1;
    assign o_cero = r_cuenta == '0;
endmodule

// File: rtl/controlador_minado.sv
// controlador_minado: nonce-search sequencer; `define CONTADOR_CICLOS_EN adds the ciclos busy-cycle counter
module controlador_minado
    import controlador_minado_pkg::*;
#(
    parameter int                 LATENCIA  = 1,
    parameter logic [NONCE_W-1:0] NONCE_MAX = 32'hFFFF_FFFF
) (
    input logic                 clk,
    input logic                 reset,
    controlador_minado_if.slave bus
);
    localparam logic [CUENTA_W-1:0] CARGA = CUENTA_W'(LATENCIA - 1);
    estado_t             r_estado, w_siguiente;
    logic [DATA_W-1:0]   r_datos;
    logic [TARGET_W-1:0] r_target;
    logic [NONCE_W-1:0]  r_nonce, r_nonce_enc;
    logic [HASH_W-1:0]   r_hash_enc;
    logic                w_cero, w_aceptar, w_avanzar, w_exito, w_ocupado;
    contador_espera u_espera (
        .clk           (clk),
        .reset         (reset),
        .i_cargar      (w_aceptar || w_avanzar),
        .i_valor       (CARGA),
        .i_decrementar (r_estado == ESPERAR),
        .o_cero        (w_cero)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) r_estado <= REPOSO;
        else r_estado <= w_siguiente;
    // a dropped request wins over everything, including a same-cycle hit
    always_comb begin
        w_siguiente = r_estado;
        case (r_estado)
            REPOSO:         w_siguiente = bus.inicio ? ESPERAR : REPOSO;
            ESPERAR:        w_siguiente = !bus.inicio ? REPOSO : w_cero ? EVALUAR : ESPERAR;
            EVALUAR:        w_siguiente = !bus.inicio ? REPOSO : bus.hash_terminado ? EXITO :
                                          r_nonce == NONCE_MAX ? AGOTADO : ESPERAR;
            EXITO, AGOTADO: w_siguiente = bus.inicio ? r_estado : REPOSO;
            default:        w_siguiente = REPOSO;
        endcase
    end
    always_comb begin
        w_ocupado = r_estado == ESPERAR || r_estado == EVALUAR;
        w_aceptar = r_estado == REPOSO && bus.inicio;
        w_avanzar = r_estado == EVALUAR && w_siguiente == ESPERAR;
        w_exito   = r_estado == EVALUAR && w_siguiente == EXITO;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_datos     <= '0;
            r_target    <= '0;
            r_nonce     <= '0;
            r_nonce_enc <= '0;
            r_hash_enc  <= '0;
        end else if (w_aceptar) begin
            r_datos     <= bus.bloque_datos;
            r_target    <= bus.target;
            r_nonce     <= '0;
            r_nonce_enc <= '0;
            r_hash_enc  <= '0;
        end else if (w_avanzar) begin
            r_nonce     <= r_nonce + 1'b1;
        end else if (w_exito) begin
            r_nonce_enc <= r_nonce;
            r_hash_enc  <= bus.hash_bounty;
        end
`ifdef CONTADOR_CICLOS_EN
    logic [31:0] r_ciclos;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_ciclos <= '0;
        else if (w_aceptar) r_ciclos <= '0;
        else if (w_ocupado && r_ciclos != '1) r_ciclos <= r_ciclos + 1'b1;
    assign bus.ciclos = r_ciclos;
`endif
    assign bus.bloque           = {r_datos, r_nonce};
    assign bus.target_out       = r_target;
    assign bus.ocupado          = w_ocupado;
    assign bus.terminado        = r_estado == EXITO;
    assign bus.agotado          = r_estado == AGOTADO;
    assign bus.nonce_encontrado = r_nonce_enc;
    assign bus.hash_encontrado  = r_hash_enc;
endmodule

// File: tb/tb_controlador_minado.sv
// tb_controlador_minado: scoreboard bench; dut a = LATENCIA 1 full nonce space, dut b = LATENCIA 2 NONCE_MAX 7
module tb_controlador_minado;
    typedef struct {
        bit          exito;
        logic [31:0] nonce;
        logic [23:0] hash;
        int          edges;
    } esperado_t;
    typedef struct packed {
        logic [127:0] bloque;
        logic [7:0]   target_out;
        logic         ocupado;
        logic         terminado;
        logic         agotado;
        logic [31:0]  nonce_enc;
        logic [23:0]  hash_enc;
    } obs_t;
    localparam logic [95:0] PATRON = {12{8'hA5}};
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hit_en_a = 1'b0, hit_en_b = 1'b0;
    logic [31:0] hit_a = '0, hit_b = '0;
    int          total = 0, bad = 0, edges = 0;
    int          pres [8];
    bit          cur = 1'b0;
    esperado_t   sb [$];
    obs_t        oa, ob;
    controlador_minado_if ia ();
    controlador_minado_if ib ();
    controlador_minado #(.LATENCIA(1)) u_a (.clk(clk), .reset(reset), .bus(ia));
    controlador_minado #(.LATENCIA(2), .NONCE_MAX(32'd7)) u_b (.clk(clk), .reset(reset), .bus(ib));
    always #5 clk = ~clk;
    assign ia.hash_terminado = hit_en_a && ia.bloque[31:0] == hit_a;
    assign ia.hash_bounty    = ia.bloque[31:0] == hit_a ? 24'h0A0B0C : {16'hDEAD, ia.bloque[7:0]};
    assign ib.hash_terminado = hit_en_b && ib.bloque[31:0] == hit_b;
    assign ib.hash_bounty    = ib.bloque[31:0] == hit_b ? 24'h0A0B0C : {16'hDEAD, ib.bloque[7:0]};
    assign oa = {ia.bloque, ia.target_out, ia.ocupado, ia.terminado, ia.agotado,
                 ia.nonce_encontrado, ia.hash_encontrado};
    assign ob = {ib.bloque, ib.target_out, ib.ocupado, ib.terminado, ib.agotado,
                 ib.nonce_encontrado, ib.hash_encontrado};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t o(input bit s);
        return s ? ob : oa;
    endfunction

    task automatic tick();
        obs_t x;
        @(posedge clk);
        #1;
        edges++;
        x = o(cur);
        if (x.ocupado && x.bloque[31:0] < 32'd8) pres[x.bloque[2:0]]++;
    endtask

    task automatic aceptar(input bit s, input logic [95:0] d, input logic [7:0] t);
        obs_t x;
        cur = s;
        foreach (pres[i]) pres[i] = 0;
        if (s) begin
            ib.bloque_datos = d;
            ib.target = t;
            ib.inicio = 1'b1;
        end else begin
            ia.bloque_datos = d;
            ia.target = t;
            ia.inicio = 1'b1;
        end
        tick();
        edges = 0;
        x = o(s);
        chk("acepta_ocupado", x.ocupado, 1'b1);
        chk("acepta_bloque", x.bloque, {d, 32'h0});
        chk("acepta_target", x.target_out, t);
        chk("acepta_nonce_enc", x.nonce_enc, 32'h0);
        chk("acepta_hash_enc", x.hash_enc, 24'h0);
    endtask

    task automatic terminar();
        esperado_t e;
        obs_t x;
        x = o(cur);
        while (!(x.terminado || x.agotado) && edges < 300) begin
            tick();
            x = o(cur);
        end
        chk("fin_alcanzado", x.terminado || x.agotado, 1'b1);
        if (sb.size() == 0) begin
            chk("sb_vacio", 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        chk("flanco_fin", edges, e.edges);
        chk("terminado", x.terminado, e.exito);
        chk("agotado", x.agotado, !e.exito);
        chk("ocupado_fin", x.ocupado, 1'b0);
        chk("nonce_final", x.bloque[31:0], e.nonce);
        chk("nonce_enc", x.nonce_enc, e.exito ? e.nonce : 32'h0);
        chk("hash_enc", x.hash_enc, e.exito ? e.hash : 24'h0);
    endtask

    initial begin
        ia.inicio = 1'b0; ia.bloque_datos = '0; ia.target = '0;
        ib.inicio = 1'b0; ib.bloque_datos = '0; ib.target = '0;
        repeat (2) tick();
        chk("reset_a", oa, '0);
        chk("reset_b", ob, '0);
        reset = 1'b0;
        tick();
        hit_a = 32'd5;
        hit_en_a = 1'b1;
        sb.push_back('{1'b1, 32'd5, 24'h0A0B0C, 12});
        aceptar(1'b0, PATRON, 8'h3C);
        repeat (3) tick();
        ia.bloque_datos = '0;
        ia.target = '0;
        tick();
        chk("aislado_datos", oa.bloque[127:32], PATRON);
        chk("aislado_target", oa.target_out, 8'h3C);
        terminar();
        tick();
        chk("exito_retenido", oa.terminado, 1'b1);
        chk("exito_nonce_ret", oa.nonce_enc, 32'd5);
        ia.inicio = 1'b0;
        tick();
        chk("libera_terminado", oa.terminado, 1'b0);
        chk("libera_ocupado", oa.ocupado, 1'b0);
        chk("persiste_nonce", oa.nonce_enc, 32'd5);
        chk("persiste_hash", oa.hash_enc, 24'h0A0B0C);
        hit_a = 32'd0;
        aceptar(1'b0, 96'h1, 8'h01);
        tick();
        ia.inicio = 1'b0;
        tick();
        chk("prio_abort_term", oa.terminado, 1'b0);
        chk("prio_abort_ocup", oa.ocupado, 1'b0);
        chk("prio_abort_nonce", oa.nonce_enc, 32'h0);
        hit_en_a = 1'b0;
        sb.push_back('{1'b0, 32'd7, 24'h0, 24});
        aceptar(1'b1, 96'hCAFE, 8'h55);
        terminar();
        for (int k = 0; k < 8; k++) chk($sformatf("presenta_%0d", k), pres[k], 3);
        tick();
        chk("agotado_retenido", ob.agotado, 1'b1);
        chk("agotado_nonce", ob.bloque[31:0], 32'd7);
        ib.inicio = 1'b0;
        tick();
        chk("libera_agotado", ob.agotado, 1'b0);
        aceptar(1'b1, 96'h1111, 8'h11);
        repeat (9) tick();
        chk("abort_pre_nonce", ob.bloque[31:0], 32'd3);
        ib.inicio = 1'b0;
        tick();
        chk("abort_ocupado", ob.ocupado, 1'b0);
        chk("abort_terminado", ob.terminado, 1'b0);
        chk("abort_agotado", ob.agotado, 1'b0);
        aceptar(1'b1, 96'h2222, 8'h22);
        repeat (12) tick();
        chk("pre_reset_nonce", ob.bloque[31:0], 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_asinc", ob, '0);
        ib.inicio = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("tras_reset", ob, '0);
        hit_a = 32'd2;
        hit_en_a = 1'b1;
        sb.push_back('{1'b1, 32'd2, 24'h0A0B0C, 6});
        aceptar(1'b0, 96'h3333, 8'h33);
        terminar();
`ifdef CONTADOR_CICLOS_EN
        chk("ciclos", ia.ciclos, 32'd6);
        tick();
        chk("ciclos_retenido", ia.ciclos, 32'd6);
`endif
        ia.inicio = 1'b0;
        tick();
        chk("sb_consumido", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controlador_minado.md
Name: controlador_minado

Overview:
- Sequencer for the micro-UCR nonce-search datapath (block loader, W expansion, 24-bit hash, target comparator).
- Captures a 96-bit data block and an 8-bit target on request, then walks the 32-bit nonce upward one candidate at a time.
- Waits a fixed datapath latency per candidate, then samples the comparator verdict.
- Stops on the first hit or when the nonce space is exhausted, and holds the result until the request is withdrawn.

Parameters:
LATENCIA, 1, cycles from a stable `bloque` to a valid `hash_terminado`/`hash_bounty`; legal range 1..15.
NONCE_MAX, 32'hFFFF_FFFF, last nonce tried before declaring exhaustion; lowered in simulation.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state and outputs.
inicio  input  1  search request (level): held high for the whole search; low aborts or releases.
bloque_datos  input  96  data block, sampled only on acceptance.
target  input  8  difficulty target, sampled only on acceptance.
hash_terminado  input  1  comparator hit flag for the current `bloque`.
hash_bounty  input  24  comparator hash for the current `bloque`.
bloque  output  128  to datapath: [31:0] = current nonce, [127:32] = latched data.
target_out  output  8  latched target, to comparator.
ocupado  output  1  search in progress.
terminado  output  1  search ended with a hit.
agotado  output  1  search ended without a hit.
nonce_encontrado  output  32  winning nonce.
hash_encontrado  output  24  winning hash.

Behaviour:
- Reset values: all outputs, latched data/target, nonce, wait counter = 0; state = REPOSO. Reset may assert in any state and is effective immediately.
- States: REPOSO, ESPERAR, EVALUAR, EXITO, AGOTADO.
- REPOSO:
  - `ocupado=0`.
  - On an edge with `inicio=1`: latch `bloque_datos` and `target`, nonce<=0, cuenta<=LATENCIA-1, go to ESPERAR.
- ESPERAR (`ocupado=1`):
  - If cuenta==0, go to EVALUAR; else cuenta<=cuenta-1.
  - Exactly LATENCIA cycles are spent in ESPERAR per nonce.
- EVALUAR (`ocupado=1`):
  - If `hash_terminado=1`: latch nonce into `nonce_encontrado` and `hash_bounty` into `hash_encontrado`; go to EXITO.
  - Else if nonce==NONCE_MAX: go to AGOTADO. The nonce never wraps to 0.
  - Else: nonce<=nonce+1, cuenta<=LATENCIA-1, go to ESPERAR.
- Throughput: LATENCIA+1 cycles per nonce. Nonce n is evaluated in the cycle after edge n*(LATENCIA+1)+LATENCIA, counting the accepting edge as edge 0.
- EXITO: `terminado=1`, `ocupado=0`; results held stable.
- AGOTADO: `agotado=1`, `ocupado=0`; `nonce_encontrado`/`hash_encontrado` stay 0.
- Leaving EXITO/AGOTADO: `inicio=0` returns to REPOSO on the next edge. `terminado`/`agotado` clear there; found values persist until the next acceptance, which clears them to 0.
- Abort: `inicio=0` in ESPERAR or EVALUAR returns to REPOSO on that edge with no result. Abort has priority over a simultaneous hit.
- `bloque_datos`/`target` changes during a search are ignored.
- `bloque` and `target_out` are registered; the nonce field updates only on EVALUAR→ESPERAR transitions.
- `terminado` and `agotado` are never high together.

Optional Feature:
- Macro: CONTADOR_CICLOS_EN.
- Defined: adds output `ciclos` [31:0].
  - Cleared on acceptance; +1 on every edge while `ocupado=1`; saturates at all-ones; held in EXITO/AGOTADO.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - State encoding constants (REPOSO..AGOTADO, 3 bits).
  - Field widths: nonce 32, data 96, block 128, hash 24, target 8.
- Optional sub-module `contador_espera`: loadable down-counter producing the zero flag for ESPERAR. Everything else stays in one module.

Test Plan:
- Hit at nonce 5: LATENCIA=1; stub sets `hash_terminado=1`, `hash_bounty=24'h0A0B0C` when `bloque[31:0]==5`; `inicio` held high.
  -> `terminado` rises after edge 12 post-acceptance; `nonce_encontrado=5`, `hash_encontrado=24'h0A0B0C`, `ocupado=0`.
- Exhaustion: NONCE_MAX=7, LATENCIA=2, stub never hits.
  -> nonces 0..7 each presented for 3 cycles; `agotado=1` after edge 24; nonce stays 7.
- Abort: `inicio` dropped while nonce=3 in ESPERAR.
  -> REPOSO next edge; `ocupado=0`, `terminado=agotado=0`; re-raising `inicio` restarts at nonce 0 with a freshly latched block.
- Async reset mid-search at nonce 4.
  -> all outputs 0 immediately without a clock edge; REPOSO after deassertion.
- Input isolation: `bloque_datos=96'hA5..A5` at acceptance, changed to `96'h0` mid-search.
  -> `bloque[127:32]` stays `96'hA5..A5`; `target_out` unchanged.
- CONTADOR_CICLOS_EN defined, hit at nonce 2, LATENCIA=1.
  -> `ciclos=6` held in EXITO.
